phase_addr_gen: RTL and testbench
=================================

PHASE_ADDR_GEN -- requirements
Module: phase_addr_gen

Interface
REQ-001 Parameter: ADDRESS_WIDTH, 8, sine ROM address width (integer phase bits).
REQ-002 Parameter: FRAC_WIDTH, 8, fractional phase bits for sub-sample frequency resolution.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  pulse; IDLE->RUN, latches incr.
REQ-006 stop  input  1  pulse; RUN->IDLE.
REQ-007 en  input  1  advance enable while in RUN.
REQ-008 incr  input  ADDRESS_WIDTH+FRAC_WIDTH  phase step per enabled cycle.
REQ-009 offset  input  ADDRESS_WIDTH  phase offset of port 2 relative to port 1.
REQ-010 addr1  output  ADDRESS_WIDTH  ROM port-1 address.
REQ-011 addr2  output  ADDRESS_WIDTH  ROM port-2 address.
REQ-012 valid  output  1  high while in RUN.
REQ-013 wrap  output  1  one-cycle pulse on accumulator overflow.

Function
REQ-014 Two states, IDLE and RUN; encoding is an enum in the package.
REQ-015 IDLE: accumulator (acc, ADDRESS_WIDTH+FRAC_WIDTH bits) = 0, addr1 = 0, addr2 = 0, valid = 0, wrap = 0.
REQ-016 IDLE with start=1 and stop=0 at an edge: state<=RUN, incr_q<=incr, acc<=0, addr1<=0, addr2<=offset, valid<=1.
REQ-017 RUN with en=1 at an edge: acc<=(acc+incr_q) mod 2^(ADDRESS_WIDTH+FRAC_WIDTH); addr1<=new acc top ADDRESS_WIDTH bits; addr2<=(new addr1+offset) mod 2^ADDRESS_WIDTH.
REQ-018 RUN with en=0: acc and addr1 hold; addr2 still re-evaluated as (addr1+offset) mod 2^ADDRESS_WIDTH, so offset changes appear one cycle later.
REQ-019 wrap<=1 for exactly the cycle following an enabled edge where acc+incr_q carried out of the MSB; else 0.
REQ-020 stop=1 in RUN: state<=IDLE and all outputs/acc to IDLE values on that edge, no advance.
REQ-021 start and stop both 1 in any state: stop wins (IDLE result); start in RUN is ignored, incr_q unchanged.
REQ-022 incr changes during RUN have no effect until the next start.
REQ-023 incr_q=0: addresses constant, wrap never asserts.
REQ-024 Outputs all registered; addr1/addr2 drive a synchronous-read ROM directly, giving data one cycle after address.

Reset
REQ-025 rst_n=0 at an edge forces IDLE, acc=0, incr_q=0, all outputs 0, overriding start/stop/en, including mid-RUN.
REQ-026 First edge with rst_n=1 behaves as IDLE (start honoured on that edge).

Structure
REQ-027 Package phase_gen_pkg holds the state enum and default ADDRESS_WIDTH/FRAC_WIDTH constants.
REQ-028 One sub-module, phase_acc, holds acc, incr_q, adder and carry-out; FSM and offset adder stay in top.

Verification (ADDRESS_WIDTH=8, FRAC_WIDTH=8)
REQ-029 incr=0x0100, offset=0x40, start, en=1 -> addr1 0,1,2,...; addr2 0x40,0x41,...; valid=1 from first post-start cycle.
REQ-030 incr=0x0080 -> addr1 increments every second cycle (0,0,1,1,...); wrap pulses once per 512 enabled cycles.
REQ-031 incr=0x0100, offset=0xF0, run 256 cycles -> addr1 0xFF->0x00 with one-cycle wrap; addr2 wraps 0xFF->0x00 when addr1 0x0F->0x10.
REQ-032 en toggled 1,0,0,1 -> addr1 holds across en=0 cycles; offset changed 0x00->0x80 during hold -> addr2 updates next cycle.
REQ-033 start and stop same cycle in IDLE, then stop mid-RUN -> state IDLE, addr1=addr2=0, valid=0 next cycle.
REQ-034 rst_n low mid-RUN with start=1 -> all outputs 0 next cycle; incr change mid-RUN has no effect until restart.

Source files
------------

// File: rtl/phase_gen_pkg.sv
// rtl/phase_gen_pkg.sv - shared state encoding and default widths for the phase address generator
package phase_gen_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_FRAC_WIDTH    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/phase_addr_gen_if.sv
// rtl/phase_addr_gen_if.sv - control and ROM-address bundle of the phase address generator
interface phase_addr_gen_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FRAC_WIDTH    = 8
) ();

  logic                                start;
  logic                                stop;
  logic                                en;
  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr;
  logic [ADDRESS_WIDTH-1:0]            offset;
  logic [ADDRESS_WIDTH-1:0]            addr1;
  logic [ADDRESS_WIDTH-1:0]            addr2;
  logic                                valid;
  logic                                wrap;

  // Controller side: issues commands, consumes ROM addresses
  modport master (
    output start, stop, en, incr, offset,
    input  addr1, addr2, valid, wrap
  );

  // Generator side
  modport slave (
    input  start, stop, en, incr, offset,
    output addr1, addr2, valid, wrap
  );

endinterface

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - phase accumulator with latched step and carry-out
import phase_gen_pkg::*;

module phase_acc #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_load,
  input  logic                                i_clear,
  input  logic                                i_adv,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] i_incr,
  output logic [ADDRESS_WIDTH-1:0]            o_next_addr,
  output logic                                o_carry
);

  localparam int W = ADDRESS_WIDTH + FRAC_WIDTH;

  logic [W-1:0] r_acc;
  logic [W-1:0] r_incr_q;
  logic [W:0]   w_sum;

  // One extra bit catches the overflow that becomes the wrap pulse
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_incr_q};
  assign o_next_addr = w_sum[W-1:FRAC_WIDTH];
  assign o_carry     = w_sum[W];

  // Clear has priority so a stop never advances; the step is only captured on a start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_incr_q <= '0;
    end else if (i_clear) begin
      r_acc    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_incr_q <= i_incr;
    end else if (i_adv) begin
      r_acc    <= w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/phase_addr_gen.sv
// rtl/phase_addr_gen.sv - dual-port sine ROM address generator with phase offset
import phase_gen_pkg::*;

module phase_addr_gen #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  phase_addr_gen_if.slave  bus
);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr1;
  logic [ADDRESS_WIDTH-1:0] r_addr2;
  logic                     r_valid;
  logic                     r_wrap;

  logic                     w_load;
  logic                     w_adv;
  logic [ADDRESS_WIDTH-1:0] w_next_addr;
  logic                     w_carry;

  // Stop dominates start in both states, and start is ignored once running
  assign w_load = (r_state == ST_IDLE) && bus.start && !bus.stop;
  assign w_adv  = (r_state == ST_RUN) && bus.en && !bus.stop;

  phase_acc #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .FRAC_WIDTH    (FRAC_WIDTH)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_clear     (bus.stop),
    .i_adv       (w_adv),
    .i_incr      (bus.incr),
    .o_next_addr (w_next_addr),
    .o_carry     (w_carry)
  );

  assign bus.addr1 = r_addr1;
  assign bus.addr2 = r_addr2;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;

  // Control FSM with registered ROM addresses; addr2 tracks offset every running cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.stop) begin
        r_state <= ST_IDLE;
        r_addr1 <= '0;
        r_addr2 <= '0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state <= ST_RUN;
              r_addr1 <= '0;
              r_addr2 <= bus.offset;
              r_valid <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.en) begin
              r_addr1 <= w_next_addr;
              r_addr2 <= w_next_addr + bus.offset;
              r_wrap  <= w_carry;
            end else begin
              r_addr2 <= r_addr1 + bus.offset;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_addr_gen.sv
// tb/tb_phase_addr_gen.sv - randomized self-checking bench for phase_addr_gen
module tb_phase_addr_gen;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  phase_addr_gen_if #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(8)) bus ();

  phase_addr_gen #(.ADDRESS_WIDTH(8), .FRAC_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the output is a pure function of steps taken since start
  bit     armed;
  bit     m_run;
  longint m_q;
  longint m_n;
  int     e_a1, e_a2, e_v, e_w;

  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1'b1;
      m_run = 1'b0; m_q = 0; m_n = 0;
      e_a1 = 0; e_a2 = 0; e_v = 0; e_w = 0;
    end else if (bus.stop) begin
      m_run = 1'b0; m_n = 0;
      e_a1 = 0; e_a2 = 0; e_v = 0; e_w = 0;
    end else if (!m_run) begin
      e_w = 0;
      if (bus.start) begin
        m_run = 1'b1; m_q = longint'(bus.incr); m_n = 0;
        e_a1 = 0; e_a2 = int'(bus.offset); e_v = 1;
      end
    end else begin
      if (bus.en) begin
        e_w = (((m_n + 1) * m_q) / 65536) != ((m_n * m_q) / 65536) ? 1 : 0;
        m_n = m_n + 1;
      end else begin
        e_w = 0;
      end
      e_a1 = int'(((m_n * m_q) / 256) % 256);
      e_a2 = (e_a1 + int'(bus.offset)) % 256;
    end
  end

  // Compare every cycle, half a period away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (int'(bus.addr1) != e_a1 || int'(bus.addr2) != e_a2 ||
          int'(bus.valid) != e_v || int'(bus.wrap) != e_w) begin
        errors++;
        $display("FAIL model_cmp t=%0t got a1=%0h a2=%0h v=%0d w=%0d want a1=%0h a2=%0h v=%0d w=%0d",
                 $time, bus.addr1, bus.addr2, bus.valid, bus.wrap, e_a1, e_a2, e_v, e_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_stop();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  task automatic do_start(input int inc, input int off);
    bus.incr = 16'(inc); bus.offset = 8'(off);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  int wraps;

  initial begin
    checks = 0; errors = 0; armed = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b0;
    bus.incr = '0; bus.offset = '0;
    tick(); tick();
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_addr1", int'(bus.addr1), 0);
    rst_n = 1'b1;

    // Integer step, offset 0x40
    bus.en = 1'b1;
    do_start(16'h0100, 8'h40);
    chk("start_valid", int'(bus.valid), 1);
    chk("start_addr2", int'(bus.addr2), 8'h40);
    tick(); tick(); tick();
    chk("int_addr1", int'(bus.addr1), 3);
    chk("int_addr2", int'(bus.addr2), 8'h43);
    do_stop();

    // Half step: one wrap per 512 enabled cycles
    do_start(16'h0080, 8'h00);
    wraps = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (bus.wrap) wraps++;
      if (i == 2) chk("half_addr1", int'(bus.addr1), 1);
    end
    chk("half_wraps", wraps, 1);
    do_stop();

    // Address rollover on both ports
    do_start(16'h0100, 8'hF0);
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 14) chk("roll_a2_ff", int'(bus.addr2), 8'hFF);
      if (i == 15) chk("roll_a2_00", int'(bus.addr2), 8'h00);
      if (i == 254) chk("roll_nowrap", int'(bus.wrap), 0);
      if (i == 255) begin
        chk("roll_a1", int'(bus.addr1), 0);
        chk("roll_wrap", int'(bus.wrap), 1);
      end
    end
    tick();
    chk("wrap_one_cycle", int'(bus.wrap), 0);
    do_stop();

    // Enable hold with offset change
    do_start(16'h0100, 8'h00);
    tick();
    bus.en = 1'b0; tick();
    bus.offset = 8'h80; tick();
    chk("hold_addr1", int'(bus.addr1), 1);
    chk("hold_addr2", int'(bus.addr2), 8'h81);
    bus.en = 1'b1; tick();
    chk("resume_addr2", int'(bus.addr2), 8'h82);
    do_stop();

    // Start and stop together, then stop mid-run
    bus.start = 1'b1; bus.stop = 1'b1; tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_valid", int'(bus.valid), 0);
    do_start(16'h0300, 8'h10);
    tick(); tick();
    do_stop();
    chk("stop_valid", int'(bus.valid), 0);
    chk("stop_addr2", int'(bus.addr2), 0);

    // Mid-run incr change ignored, reset overrides start
    do_start(16'h0100, 8'h00);
    tick(); tick();
    bus.incr = 16'h0400; tick();
    chk("incr_ignored", int'(bus.addr1), 3);
    rst_n = 1'b0; bus.start = 1'b1; tick();
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_addr1", int'(bus.addr1), 0);
    rst_n = 1'b1; tick();
    bus.start = 1'b0;
    chk("post_rst_start", int'(bus.valid), 1);
    tick();
    chk("new_incr", int'(bus.addr1), 4);
    do_stop();

    // Zero step never wraps
    do_start(16'h0000, 8'h22);
    for (int i = 0; i < 40; i++) tick();
    chk("zero_addr1", int'(bus.addr1), 0);
    do_stop();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom % 300) != 0;
      bus.start = ($urandom % 15) == 0;
      bus.stop  = ($urandom % 60) == 0;
      bus.en    = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: bus.incr = 16'($urandom % 4);
        1: bus.incr = 16'($urandom % 1024);
        default: bus.incr = 16'($urandom);
      endcase
      if (($urandom % 8) == 0) bus.offset = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
